// File: rtl/alu_jump.sv
// Branch-target adder for the PC path: PC+imm, PC+1+imm, absolute imm, or PC+1, registered (1 cycle, no backpressure).
// Optional feature macro ALU_JUMP_RANGE_CHECK_EN: registers a wrap flag when the signed target leaves 0..2^AW-1.
module alu_jump #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [AW-1:0] in_pc,
  input  logic [AW-1:0] in_imm,
  input  logic [1:0]    mode,
  output logic [AW-1:0] out_addr,
  output logic          out_valid,
  output logic          wrap
);

  logic          w_inc;
  logic          w_abs;
  logic          w_use_imm;
  logic [AW-1:0] w_addr;
  logic [AW-1:0] r_addr;
  logic          r_valid;

  // mode[0] selects the +1; mode 10 is absolute; mode 11 drops the offset.
  assign w_inc     = mode[0];
  assign w_abs     = (mode == 2'b10);
  assign w_use_imm = (mode != 2'b11);

`ifdef ALU_JUMP_RANGE_CHECK_EN
  logic [AW+1:0] w_imm_ext;
  logic [AW+1:0] w_sum;
  logic          w_wrap;
  logic          r_wrap;

  assign w_imm_ext = w_use_imm ? {{2{in_imm[AW-1]}}, in_imm} : '0;
  assign w_sum     = {2'b00, in_pc} + {{(AW+1){1'b0}}, w_inc} + w_imm_ext;
  // Either top bit set means negative or above 2^AW-1 in the extended signed view.
  assign w_wrap    = w_abs ? 1'b0 : (|w_sum[AW+1:AW]);
  assign w_addr    = w_abs ? in_imm : w_sum[AW-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wrap <= 1'b0;
    end else if (in_valid) begin
      r_wrap <= w_wrap;
    end
  end

  assign wrap = r_wrap;
`else
  logic [AW-1:0] w_imm_lo;
  logic [AW-1:0] w_sum_lo;

  assign w_imm_lo = w_use_imm ? in_imm : '0;
  assign w_sum_lo = in_pc + {{(AW-1){1'b0}}, w_inc} + w_imm_lo;
  assign w_addr   = w_abs ? in_imm : w_sum_lo;
  assign wrap     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_addr  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_addr <= w_addr;
      end
    end
  end

  assign out_addr  = r_addr;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_alu_jump.sv
// Scoreboard bench for alu_jump; expected wrap follows ALU_JUMP_RANGE_CHECK_EN.
module tb_alu_jump;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_pc;
  logic [7:0] in_imm;
  logic [1:0] mode;
  logic [7:0] out_addr;
  logic       out_valid;
  logic       wrap;

  typedef struct {
    logic [7:0] addr;
    logic       wrap;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] last_addr;
  logic       last_wrap;
  int         n_checks = 0;
  int         n_fail   = 0;

  alu_jump #(.AW(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_pc    (in_pc),
    .in_imm   (in_imm),
    .mode     (mode),
    .out_addr (out_addr),
    .out_valid(out_valid),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] m, input logic [7:0] pc, input logic [7:0] imm);
    exp_t e;
    int   s;
    logic [31:0] sv;
    s = int'(pc);
    if (m[0]) s = s + 1;
    if (m != 2'b11) s = s + int'($signed(imm));
    sv = s;
    e.addr = (m == 2'b10) ? imm : sv[7:0];
`ifdef ALU_JUMP_RANGE_CHECK_EN
    e.wrap = (m == 2'b10) ? 1'b0 : ((s < 0) || (s > 255));
`else
    e.wrap = 1'b0;
`endif
    return e;
  endfunction

  task automatic step(input string tag, input logic v, input logic [1:0] m,
                      input logic [7:0] pc, input logic [7:0] imm);
    exp_t e;
    in_valid = v;
    mode     = m;
    in_pc    = pc;
    in_imm   = imm;
    if (v) sb_q.push_back(model(m, pc, imm));
    @(posedge clk);
    #1;
    if (v) begin
      e = sb_q.pop_front();
      check({tag, ".addr"},  {24'h0, out_addr}, {24'h0, e.addr});
      check({tag, ".valid"}, {31'h0, out_valid}, 32'h1);
      check({tag, ".wrap"},  {31'h0, wrap}, {31'h0, e.wrap});
      last_addr = e.addr;
      last_wrap = e.wrap;
    end else begin
      check({tag, ".hold_addr"}, {24'h0, out_addr}, {24'h0, last_addr});
      check({tag, ".valid0"},    {31'h0, out_valid}, 32'h0);
      check({tag, ".hold_wrap"}, {31'h0, wrap}, {31'h0, last_wrap});
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_pc    = 8'h00;
    in_imm   = 8'h00;
    mode     = 2'b00;
    last_addr = 8'h00;
    last_wrap = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst.addr",  {24'h0, out_addr}, 32'h0);
    check("rst.valid", {31'h0, out_valid}, 32'h0);
    check("rst.wrap",  {31'h0, wrap}, 32'h0);

    step("neg_off",   1'b1, 2'b00, 8'h01, 8'h80);
    step("pos_off",   1'b1, 2'b00, 8'h0F, 8'h04);
    step("neg_a",     1'b1, 2'b00, 8'h61, 8'h8C);
    step("neg_b",     1'b1, 2'b00, 8'h03, 8'h84);
    step("pc1_wrap",  1'b1, 2'b01, 8'hFE, 8'h01);
    step("absolute",  1'b1, 2'b10, 8'h33, 8'h5A);
    step("pc_inc",    1'b1, 2'b11, 8'hFF, 8'h7F);
    step("pc_inc_nw", 1'b1, 2'b11, 8'h10, 8'h80);
    step("max_pos",   1'b1, 2'b01, 8'hFF, 8'h7F);
    for (int i = 0; i < 3; i++) step("idle", 1'b0, 2'b00, 8'hAA, 8'h55);

    for (int i = 0; i < 40; i++)
      step("rand", ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
           8'($urandom), 8'($urandom));

    // Load a wrapping result, then reset while a request is presented.
    step("pre_rst", 1'b1, 2'b00, 8'h01, 8'h80);
    rst_n    = 1'b0;
    in_valid = 1'b1;
    mode     = 2'b00;
    in_pc    = 8'h40;
    in_imm   = 8'h05;
    @(posedge clk);
    #1;
    check("mid_rst.addr",  {24'h0, out_addr}, 32'h0);
    check("mid_rst.valid", {31'h0, out_valid}, 32'h0);
    check("mid_rst.wrap",  {31'h0, wrap}, 32'h0);
    rst_n     = 1'b1;
    last_addr = 8'h00;
    last_wrap = 1'b0;
    step("post_rst", 1'b0, 2'b00, 8'h40, 8'h05);
    step("resume",   1'b1, 2'b00, 8'h40, 8'h05);
    check("sb_empty", sb_q.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
